// File: rtl/tap_selector_pkg.sv
// Shared types and constants for the tap selector and its duplicate checker.
package tap_selector_pkg;

    localparam int REJ_CNT_W = 16;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FIXUP   = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Elaboration-time ceil(log2(value)); loop form keeps it usable in synthesis.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tap_dup_check.sv
// Parallel comparator: flags a candidate that equals any stored tap slot.
module tap_dup_check
    import tap_selector_pkg::*;
#(
    parameter int NUM_TAPS = 15,
    parameter int TAP_W    = 8
) (
    input  logic [TAP_W-1:0]          i_cand,
    input  logic [NUM_TAPS*TAP_W-1:0] i_slots,
    output logic                      o_dup
);

    // NOTE: default assigned before the loop so no path leaves o_dup unassigned (no latch).
    always_comb begin
        o_dup = 1'b0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (i_slots[i*TAP_W +: TAP_W] == i_cand) begin
                o_dup = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tap_selector.sv
// Collects NUM_TAPS distinct feedback taps in 1..MAX_TAP from a random byte stream,
// forcing MAX_TAP into slot 1 when the stream never produced it.
module tap_selector
    import tap_selector_pkg::*;
#(
    parameter int NUM_TAPS = 15,
    parameter int MAX_TAP  = 19,
    parameter int DIN_W    = 8,
    parameter int TAP_W    = 8
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      ena,
    input  logic                      clr,
    input  logic [DIN_W-1:0]          din,
    input  logic                      take,
    output logic [NUM_TAPS*TAP_W-1:0] taps,
    output logic                      acc,
    output logic [REJ_CNT_W-1:0]      rej_cnt,
    output logic                      done
);

    localparam int                CW          = clog2(MAX_TAP + 1);
    localparam int                CNT_W       = clog2(NUM_TAPS + 1);
    localparam logic [CW-1:0]     MAX_CAND    = CW'(MAX_TAP);
    localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(NUM_TAPS);
    localparam logic [CNT_W-1:0]  FIRST_CNT   = CNT_W'(1);
    localparam logic [TAP_W-1:0]  MAX_TAP_VAL = TAP_W'(MAX_TAP);

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic [NUM_TAPS*TAP_W-1:0] r_taps;
    logic [CNT_W-1:0]          r_count;
    logic                      r_occurred;
    logic                      r_acc;
    logic [REJ_CNT_W-1:0]      r_rej_cnt;

    logic [CW-1:0]             w_cand;
    logic [TAP_W-1:0]          w_cand_ext;
    logic                      w_dup;
    logic                      w_in_range;
    logic                      w_accept;
    logic                      w_reject;

    assign w_cand     = din[CW-1:0];
    assign w_cand_ext = TAP_W'(w_cand);
    assign w_in_range = (w_cand != '0) && (w_cand <= MAX_CAND);

    // Empty slots hold 0 and 0 is out of range, so checking all slots is exact.
    tap_dup_check #(
        .NUM_TAPS (NUM_TAPS),
        .TAP_W    (TAP_W)
    ) u_dup_check (
        .i_cand  (w_cand_ext),
        .i_slots (r_taps),
        .o_dup   (w_dup)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            COLLECT: begin
                if (ena && take && !clr) begin
                    if (w_in_range && !w_dup) begin
                        w_accept = 1'b1;
                        if (r_count == LAST_CNT) begin
                            w_state_nxt = FIXUP;
                        end
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            FIXUP:   w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = COLLECT;
        endcase
        if (clr) begin
            w_state_nxt = COLLECT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the tap slots are plain flops, not a RAM, so they are reset with everything else.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_taps     <= '0;
            r_count    <= FIRST_CNT;
            r_occurred <= 1'b0;
            r_rej_cnt  <= '0;
            r_acc      <= 1'b0;
        end else if (clr) begin
            r_taps     <= '0;
            r_count    <= FIRST_CNT;
            r_occurred <= 1'b0;
            r_rej_cnt  <= '0;
            r_acc      <= 1'b0;
        end else begin
            r_acc <= w_accept;
            if (w_accept) begin
                for (int i = 0; i < NUM_TAPS; i++) begin
                    if (CNT_W'(i + 1) == r_count) begin
                        r_taps[i*TAP_W +: TAP_W] <= w_cand_ext;
                    end
                end
                if (r_count != LAST_CNT) begin
                    r_count <= r_count + FIRST_CNT;
                end
                if (w_cand == MAX_CAND) begin
                    r_occurred <= 1'b1;
                end
            end
            if (w_reject && (r_rej_cnt != '1)) begin
                r_rej_cnt <= r_rej_cnt + REJ_CNT_W'(1);
            end
            // MAX_TAP is known absent here, so overwriting slot 1 cannot create a duplicate.
            if ((r_state == FIXUP) && !r_occurred) begin
                r_taps[TAP_W-1:0] <= MAX_TAP_VAL;
            end
        end
    end

    assign taps    = r_taps;
    assign acc     = r_acc;
    assign rej_cnt = r_rej_cnt;
    assign done    = (r_state == DONE);

endmodule

// File: tb/tb_tap_selector.sv
// Directed bench for tap_selector: a 4-tap instance for the scenarios, a default instance for the random run.
module tb_tap_selector;

    logic        clk = 1'b0;
    logic        res;
    logic        ena, clr, take;
    logic [7:0]  din;
    logic [31:0] taps;
    logic        acc, done;
    logic [15:0] rej_cnt;

    logic         ena15, clr15, take15;
    logic [7:0]   din15;
    logic [119:0] taps15;
    logic         acc15, done15;
    logic [15:0]  rej15;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tap_selector #(.NUM_TAPS(4), .MAX_TAP(19), .DIN_W(8), .TAP_W(8)) dut (
        .clk(clk), .res(res), .ena(ena), .clr(clr), .din(din), .take(take),
        .taps(taps), .acc(acc), .rej_cnt(rej_cnt), .done(done)
    );

    tap_selector dut15 (
        .clk(clk), .res(res), .ena(ena15), .clr(clr15), .din(din15), .take(take15),
        .taps(taps15), .acc(acc15), .rej_cnt(rej15), .done(done15)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1; ena = 1'b1; clr = 1'b0; take = 1'b0; din = 8'h00;
        ena15 = 1'b0; clr15 = 1'b0; take15 = 1'b0; din15 = 8'h00;
        #12;
        total++; if (taps !== 32'h0) begin bad++; $display("FAIL reset_taps got=%h exp=%h", taps, 32'h0); end
        total++; if (acc !== 1'b0) begin bad++; $display("FAIL reset_acc got=%b exp=0", acc); end
        total++; if (rej_cnt !== 16'h0) begin bad++; $display("FAIL reset_rej got=%h exp=0", rej_cnt); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (done15 !== 1'b0) begin bad++; $display("FAIL reset_done15 got=%b exp=0", done15); end
        @(negedge clk);
        res = 1'b0;
    endtask

    task automatic test_fill_no_fixup();
        logic [7:0] vals [4] = '{8'h03, 8'h07, 8'h0B, 8'h13};
        int acc_pulses = 0;
        take = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = vals[i];
            tick();
            if (acc === 1'b1) acc_pulses++;
            if (i == 0) begin
                total++; if (taps !== 32'h00000003) begin bad++; $display("FAIL fill_first_slot got=%h exp=%h", taps, 32'h3); end
            end
        end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL fill_done_early got=%b exp=0", done); end
        take = 1'b0;
        tick();
        if (acc === 1'b1) acc_pulses++;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL fill_done got=%b exp=1", done); end
        total++; if (taps !== 32'h130B0703) begin bad++; $display("FAIL fill_taps got=%h exp=%h", taps, 32'h130B0703); end
        total++; if (acc_pulses !== 4) begin bad++; $display("FAIL fill_acc_pulses got=%0d exp=4", acc_pulses); end
    endtask

    task automatic test_reject();
        logic [7:0] vals [6] = '{8'h00, 8'h14, 8'h1F, 8'h05, 8'h05, 8'h25};
        do_clr();
        total++; if (done !== 1'b0 || taps !== 32'h0) begin bad++; $display("FAIL clr_state got done=%b taps=%h exp done=0 taps=0", done, taps); end
        take = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = vals[i];
            tick();
        end
        take = 1'b0;
        tick();
        total++; if (rej_cnt !== 16'd5) begin bad++; $display("FAIL rej_count got=%0d exp=5", rej_cnt); end
        total++; if (taps !== 32'h00000005) begin bad++; $display("FAIL rej_taps got=%h exp=%h", taps, 32'h5); end
        take = 1'b1; din = 8'h06;
        tick();
        take = 1'b0;
        total++; if (taps !== 32'h00000605) begin bad++; $display("FAIL rej_next_slot got=%h exp=%h", taps, 32'h605); end
        total++; if (rej_cnt !== 16'd5) begin bad++; $display("FAIL rej_hold got=%0d exp=5", rej_cnt); end
    endtask

    task automatic test_fixup();
        do_clr();
        take = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = 8'(i);
            tick();
        end
        take = 1'b0;
        total++; if (taps !== 32'h04030201) begin bad++; $display("FAIL fixup_pre got=%h exp=%h", taps, 32'h04030201); end
        tick();
        total++; if (taps !== 32'h04030213) begin bad++; $display("FAIL fixup_taps got=%h exp=%h", taps, 32'h04030213); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL fixup_done got=%b exp=1", done); end
    endtask

    task automatic test_done_hold_and_clr();
        take = 1'b1; din = 8'h09;
        tick();
        total++; if (taps !== 32'h04030213) begin bad++; $display("FAIL done_frozen got=%h exp=%h", taps, 32'h04030213); end
        total++; if (acc !== 1'b0 || rej_cnt !== 16'd0) begin bad++; $display("FAIL done_ignore got acc=%b rej=%0d exp acc=0 rej=0", acc, rej_cnt); end
        clr = 1'b1;
        tick();
        total++; if (taps !== 32'h0 || done !== 1'b0 || acc !== 1'b0) begin bad++; $display("FAIL clr_take got taps=%h done=%b acc=%b exp 0", taps, done, acc); end
        clr = 1'b0; take = 1'b0;
        tick();
        total++; if (taps !== 32'h0) begin bad++; $display("FAIL clr_drop got=%h exp=0", taps); end
    endtask

    task automatic test_ena_low();
        take = 1'b1; din = 8'h03;
        tick();
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL ena_accept got=%b exp=1", acc); end
        ena = 1'b0; din = 8'h07;
        tick();
        total++; if (acc !== 1'b0 || taps !== 32'h03) begin bad++; $display("FAIL ena_low_hold got acc=%b taps=%h exp acc=0 taps=3", acc, taps); end
        din = 8'h00;
        tick();
        total++; if (rej_cnt !== 16'd0) begin bad++; $display("FAIL ena_low_rej got=%0d exp=0", rej_cnt); end
        ena = 1'b1; take = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        do_clr();
        take = 1'b1; din = 8'h03;
        tick();
        din = 8'h07;
        tick();
        take = 1'b0;
        total++; if (taps !== 32'h0703) begin bad++; $display("FAIL ares_pre got=%h exp=%h", taps, 32'h0703); end
        #3 res = 1'b1;
        #1;
        total++; if (taps !== 32'h0 || done !== 1'b0 || acc !== 1'b0) begin bad++; $display("FAIL ares_now got taps=%h done=%b acc=%b exp 0", taps, done, acc); end
        #2 res = 1'b0;
        take = 1'b1; din = 8'h0A;
        tick();
        take = 1'b0;
        total++; if (taps !== 32'h0A) begin bad++; $display("FAIL ares_restart got=%h exp=%h", taps, 32'h0A); end
    endtask

    task automatic test_random_ena();
        logic [119:0] m_taps = '0;
        int  m_cnt = 1, m_phase = 0, m_rej = 0;
        bit  m_occ = 1'b0, m_acc, dupf, seen19;
        logic [4:0] cand;
        logic [7:0] a, b;
        int cyc;
        take15 = 1'b1;
        for (cyc = 0; cyc < 3000 && m_phase != 2; cyc++) begin
            ena15 = (cyc % 2 == 0);
            din15 = 8'($urandom);
            tick();
            m_acc = 1'b0;
            if (m_phase == 1) begin
                if (!m_occ) m_taps[7:0] = 8'd19;
                m_phase = 2;
            end else if (m_phase == 0 && ena15) begin
                cand = din15[4:0];
                dupf = 1'b0;
                for (int j = 0; j < 15; j++) if (m_taps[j*8 +: 8] == {3'b0, cand}) dupf = 1'b1;
                if (cand >= 5'd1 && cand <= 5'd19 && !dupf) begin
                    m_taps[(m_cnt-1)*8 +: 8] = {3'b0, cand};
                    if (cand == 5'd19) m_occ = 1'b1;
                    m_acc = 1'b1;
                    if (m_cnt == 15) m_phase = 1; else m_cnt++;
                end else begin
                    m_rej++;
                end
            end
            total++;
            if (acc15 !== m_acc || rej15 !== 16'(m_rej) || taps15 !== m_taps || done15 !== (m_phase == 2)) begin
                bad++;
                $display("FAIL rand_cyc%0d got acc=%b rej=%0d done=%b taps=%h exp acc=%b rej=%0d done=%b taps=%h",
                         cyc, acc15, rej15, done15, taps15, m_acc, m_rej, m_phase == 2, m_taps);
            end
        end
        take15 = 1'b0;
        total++; if (done15 !== 1'b1) begin bad++; $display("FAIL rand_timeout got done=%b exp=1", done15); end
        seen19 = 1'b0;
        dupf = 1'b0;
        for (int i = 0; i < 15; i++) begin
            a = taps15[i*8 +: 8];
            if (a == 8'd19) seen19 = 1'b1;
            if (a < 8'd1 || a > 8'd19) dupf = 1'b1;
            for (int j = i + 1; j < 15; j++) begin
                b = taps15[j*8 +: 8];
                if (a == b) dupf = 1'b1;
            end
        end
        total++; if (dupf !== 1'b0) begin bad++; $display("FAIL rand_unique_range got bad_set=%b exp=0 taps=%h", dupf, taps15); end
        total++; if (seen19 !== 1'b1) begin bad++; $display("FAIL rand_has19 got=%b exp=1", seen19); end
    endtask

    initial begin
        test_reset();
        test_fill_no_fixup();
        test_reject();
        test_fixup();
        test_done_hold_and_clr();
        test_ena_low();
        test_async_reset();
        test_random_ena();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
